// File: rtl/m31_pkg.sv
// Shared Mersenne-31 field types, operation modes and the 33-bit fold helper
// used by the multiplier and by adder datapaths.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    MUL = 2'd0,
    SQR = 2'd1,
    MAC = 2'd2,
    RSV = 2'd3
  } m31_mul_mode_e;

  // Any 33-bit sum up to 3*(2^31-1) reduces to a canonical value with two end-around carries.
  function automatic m31_t m31_fold33(input logic [32:0] sum);
    logic [31:0] s1;
    m31_t        s2;
    s1 = {1'b0, sum[30:0]} + {30'd0, sum[32:31]};
    s2 = s1[30:0] + {30'd0, s1[31]};
    if (s2 == P_M31) begin
      return 31'd0;
    end else begin
      return s2;
    end
  endfunction

endpackage

// File: rtl/m31_mul_lane.sv
// One lane of the M31 multiplier: MUL_STAGES product registers, a fold
// register holding the 33-bit partial sum, and a canonical result register.
module m31_mul_lane
  import m31_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sqr,
  input  logic fold_mac,
  input  m31_t a,
  input  m31_t b,
  input  m31_t c,
  output m31_t res
);

  localparam int PL = MUL_STAGES - 1;

  logic [61:0] prod_r [MUL_STAGES];
  m31_t        c_r    [MUL_STAGES];
  logic [32:0] sum_r;
  m31_t        res_r;
  m31_t        b_eff_s;
  m31_t        c_add_s;
  logic [32:0] sum_s;

  // Operand selection: squaring reuses a as the second factor.
  always_comb begin
    b_eff_s = b;
    if (sqr) begin
      b_eff_s = a;
    end else begin
      b_eff_s = b;
    end
  end

  // Fold: high half + low half of the product plus the addend (MAC only).
  always_comb begin
    c_add_s = 31'd0;
    if (fold_mac) begin
      c_add_s = c_r[PL];
    end else begin
      c_add_s = 31'd0;
    end
    sum_s = {2'b00, prod_r[PL][61:31]} + {2'b00, prod_r[PL][30:0]} + {2'b00, c_add_s};
  end

  // Pipeline registers; the whole lane freezes when en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_STAGES; k++) begin
        prod_r[k] <= 62'd0;
        c_r[k]    <= 31'd0;
      end
      sum_r <= 33'd0;
      res_r <= 31'd0;
    end else if (en) begin
      prod_r[0] <= {31'd0, a} * {31'd0, b_eff_s};
      c_r[0]    <= c;
      for (int k = 1; k < MUL_STAGES; k++) begin
        prod_r[k] <= prod_r[k-1];
        c_r[k]    <= c_r[k-1];
      end
      sum_r <= sum_s;
      res_r <= m31_fold33(sum_r);
    end
  end

  assign res = res_r;

endmodule

// File: rtl/m31_mul_vec.sv
// Multi-lane M31 multiply / square / multiply-accumulate engine with a single
// valid/ready handshake; a global enable stalls every stage, bubbles included.
module m31_mul_vec
  import m31_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  m31_t [LANES-1:0]       in_a,
  input  m31_t [LANES-1:0]       in_b,
  input  m31_t [LANES-1:0]       in_c,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output m31_t [LANES-1:0]       out_res,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int NST  = MUL_STAGES + 2;
  localparam int LAST = NST - 1;

  logic            valid_r [NST];
  logic [TAG_W-1:0] tag_r  [NST];
  m31_mul_mode_e   mode_r  [MUL_STAGES];

  m31_mul_mode_e   mode_in_s;
  logic            stall_s;
  logic            en_s;
  logic            sqr_s;
  logic            fold_mac_s;

  assign mode_in_s  = m31_mul_mode_e'(in_mode);
  assign stall_s    = valid_r[LAST] && !out_ready;
  assign en_s       = !stall_s;
  assign in_ready   = en_s;
  assign sqr_s      = (mode_in_s == SQR);
  // Mode only matters again at the fold stage, so it rides the chain that far.
  assign fold_mac_s = (mode_r[MUL_STAGES-1] == MAC);

  // Shared valid/tag/mode shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NST; k++) begin
        valid_r[k] <= 1'b0;
        tag_r[k]   <= '0;
      end
      for (int k = 0; k < MUL_STAGES; k++) begin
        mode_r[k] <= MUL;
      end
    end else if (en_s) begin
      valid_r[0] <= in_valid;
      tag_r[0]   <= in_tag;
      mode_r[0]  <= mode_in_s;
      for (int k = 1; k < NST; k++) begin
        valid_r[k] <= valid_r[k-1];
        tag_r[k]   <= tag_r[k-1];
      end
      for (int k = 1; k < MUL_STAGES; k++) begin
        mode_r[k] <= mode_r[k-1];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    m31_mul_lane #(
      .MUL_STAGES(MUL_STAGES)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en_s),
      .sqr     (sqr_s),
      .fold_mac(fold_mac_s),
      .a       (in_a[i]),
      .b       (in_b[i]),
      .c       (in_c[i]),
      .res     (out_res[i])
    );
  end

  assign out_valid = valid_r[LAST];
  assign out_tag   = tag_r[LAST];

endmodule

// File: tb/tb_m31_mul_vec.sv
// Randomised and directed bench for m31_mul_vec against a plain-arithmetic
// (a*b + c_eff) mod p reference with a FIFO scoreboard.
module tb_m31_mul_vec;
  import m31_pkg::*;

  localparam int LANES      = 4;
  localparam int MUL_STAGES = 2;
  localparam int TAG_W      = 8;
  localparam int LAT        = MUL_STAGES + 2;
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  m31_t [LANES-1:0] in_a;
  m31_t [LANES-1:0] in_b;
  m31_t [LANES-1:0] in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  m31_t [LANES-1:0] out_res;
  logic [TAG_W-1:0] out_tag;

  m31_mul_vec #(.LANES(LANES), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0][30:0] res;
    logic [TAG_W-1:0]       tag;
    int                     acc;
    int                     stl;
  } exp_t;

  exp_t                   q[$];
  int                     n_cmp = 0;
  int                     n_err = 0;
  int                     cyc = 0;
  int                     stall_cnt = 0;
  bit                     hold_pend = 0;
  logic [LANES-1:0][30:0] held_res;
  logic [TAG_W-1:0]       held_tag;
  logic [TAG_W-1:0]       tag_seq = 8'd0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic m31_t ref_res(input logic [1:0] mode, input m31_t a, input m31_t b, input m31_t c);
    longint unsigned aa, bb, cc;
    aa = longint'(a) % P;
    bb = (mode == 2'd1) ? aa : longint'(b) % P;
    cc = (mode == 2'd2) ? longint'(c) % P : 64'd0;
    return m31_t'((aa * bb + cc) % P);
  endfunction

  function automatic m31_t rnd31();
    case ($urandom_range(0, 7))
      0:       return 31'd0;
      1:       return 31'h7FFF_FFFF;
      2:       return 31'h7FFF_FFFE;
      3:       return 31'd1;
      default: return m31_t'($urandom);
    endcase
  endfunction

  task automatic cycle(input bit iv, input logic [1:0] md,
                       input logic [LANES-1:0][30:0] a, input logic [LANES-1:0][30:0] b,
                       input logic [LANES-1:0][30:0] c, input logic [TAG_W-1:0] tg,
                       input bit ordy, input bit use_exp, input m31_t ex,
                       output bit acc, output bit rdy, output bit ov);
    exp_t e;
    in_valid = iv; in_mode = md; in_a = a; in_b = b; in_c = c; in_tag = tg; out_ready = ordy;
    #1;
    rdy = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_res", out_res, held_res);
      check("hold_tag", out_tag, held_tag);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else begin
        e = q.pop_front();
        for (int l = 0; l < LANES; l++) check("res", out_res[l], e.res[l]);
        check("tag", out_tag, e.tag);
        check("latency", cyc - e.acc - (stall_cnt - e.stl), LAT);
      end
    end
    if (out_valid && !out_ready) begin
      stall_cnt++;
      hold_pend = 1;
      held_res  = out_res;
      held_tag  = out_tag;
    end else begin
      hold_pend = 0;
    end
    if (acc) begin
      for (int l = 0; l < LANES; l++) e.res[l] = use_exp ? ex : ref_res(md, a[l], b[l], c[l]);
      e.tag = tg;
      e.acc = cyc;
      e.stl = stall_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc, rdy, ov;
    for (int i = 0; i < n; i++) cycle(0, 2'd0, '0, '0, '0, 8'd0, 1, 0, 31'd0, acc, rdy, ov);
  endtask

  task automatic dir(input logic [1:0] md, input m31_t a, input m31_t b, input m31_t c, input m31_t ex);
    logic [LANES-1:0][30:0] va, vb, vc;
    bit acc, rdy, ov;
    for (int l = 0; l < LANES; l++) begin va[l] = a; vb[l] = b; vc[l] = c; end
    cycle(1, md, va, vb, vc, tag_seq, 1, 1, ex, acc, rdy, ov);
    check("dir_accept", acc, 1);
    tag_seq++;
  endtask

  initial begin
    logic [LANES-1:0][30:0] ra, rb, rc;
    bit acc, rdy, ov;
    int accepted, guard;

    rst_n = 0; in_valid = 0; in_mode = 2'd0; in_a = '0; in_b = '0; in_c = '0;
    in_tag = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_res", out_res, 0);
    check("reset_tag", out_tag, 0);
    check("reset_ready", in_ready, 1);
    rst_n = 1;

    // Directed corner values, back to back with mixed modes.
    dir(2'd0, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 31'd0, 31'd1);
    dir(2'd0, 31'h4000_0000, 31'd2, 31'd0, 31'd1);
    dir(2'd0, 31'h7FFF_FFFF, 31'd5, 31'd0, 31'd0);
    dir(2'd0, 31'h1234_5678, 31'd0, 31'd7, 31'd0);
    dir(2'd1, 31'd3, 31'h7FFF_0000, 31'd0, 31'd9);
    dir(2'd2, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 31'h7FFF_FFFE, 31'd0);
    dir(2'd2, 31'd2, 31'd3, 31'h7FFF_FFFE, 31'd5);
    dir(2'd3, 31'd6, 31'd7, 31'd100, 31'd42);
    idle(LAT + 2);
    check("dir_flush", q.size(), 0);

    // Random stream with random backpressure.
    accepted = 0;
    guard = 0;
    while (accepted < 100 && guard < 2000) begin
      for (int l = 0; l < LANES; l++) begin ra[l] = rnd31(); rb[l] = rnd31(); rc[l] = rnd31(); end
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ra, rb, rc,
            TAG_W'($urandom), ($urandom_range(0, 2) != 0), 0, 31'd0, acc, rdy, ov);
      if (acc) accepted++;
      guard++;
    end
    check("stream_count", accepted, 100);
    guard = 0;
    while (q.size() != 0 && guard < 30) begin
      idle(1);
      guard++;
    end
    check("stream_drain", q.size(), 0);

    // Fill the pipe, stall 5 cycles, then drain.
    for (int i = 0; i < LAT; i++) begin
      for (int l = 0; l < LANES; l++) begin ra[l] = rnd31(); rb[l] = rnd31(); rc[l] = rnd31(); end
      cycle(1, 2'd2, ra, rb, rc, tag_seq, 1, 0, 31'd0, acc, rdy, ov);
      check("fill_accept", acc, 1);
      tag_seq++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1, 2'd0, ra, rb, rc, tag_seq, 0, 0, 31'd0, acc, rdy, ov);
      check("stall_ready", rdy, 0);
      check("stall_valid", ov, 1);
    end
    for (int i = 0; i < LAT; i++) begin
      cycle(0, 2'd0, ra, rb, rc, tag_seq, 1, 0, 31'd0, acc, rdy, ov);
      check("drain_valid", ov, 1);
    end
    cycle(0, 2'd0, ra, rb, rc, tag_seq, 1, 0, 31'd0, acc, rdy, ov);
    check("drain_end", ov, 0);
    check("drain_empty", q.size(), 0);

    // Reset with three vectors in flight discards them.
    for (int i = 0; i < 3; i++) begin
      for (int l = 0; l < LANES; l++) begin ra[l] = rnd31(); rb[l] = rnd31(); rc[l] = rnd31(); end
      cycle(1, 2'd0, ra, rb, rc, tag_seq, 1, 0, 31'd0, acc, rdy, ov);
      tag_seq++;
    end
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    cyc++;
    check("midrst_valid", out_valid, 0);
    check("midrst_res", out_res, 0);
    check("midrst_ready", in_ready, 1);
    rst_n = 1;
    q.delete();
    hold_pend = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      cycle(0, 2'd0, '0, '0, '0, 8'd0, 1, 0, 31'd0, acc, rdy, ov);
      check("post_rst_idle", ov, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
